// File: rtl/rand_range_sampler_pkg.sv
// rand_range_sampler_pkg: FSM state encoding and default generator width shared by spawner blocks
package rand_range_sampler_pkg;
  localparam int RAND_W_DEF = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd1, HOLD = 2'd2} state_t;
endpackage

// File: rtl/rand_range_sampler_if.sv
// rand_range_sampler_if: generator word, request/response handshakes, bounded value, fallback flag and reject count
interface rand_range_sampler_if #(
  parameter int RAND_W = rand_range_sampler_pkg::RAND_W_DEF,
  parameter int OUT_W = 10,
  parameter int CNT_W = 16
);
  logic [RAND_W-1:0] randnum;
  logic req;
  logic req_ready;
  logic out_valid;
  logic out_ready;
  logic fallback;
  logic [OUT_W-1:0] rand_out;
  logic [CNT_W-1:0] reject_cnt;
  modport master(output randnum, req, out_ready, input req_ready, out_valid, rand_out, fallback, reject_cnt);
  modport slave(input randnum, req, out_ready, output req_ready, out_valid, rand_out, fallback, reject_cnt);
endinterface

// File: rtl/rand_range_sampler_fold.sv
// rand_range_sampler_fold: combinational XOR fold of the low and high OUT_W bits of a RAND_W word (randnum in, cand out)
module rand_range_sampler_fold #(
  parameter int RAND_W = 32,
  parameter int OUT_W = 10
) (
  input  logic [RAND_W-1:0] randnum,
  output logic [OUT_W-1:0]  cand
);
  logic unused;
  assign unused = ^randnum;
  assign cand = randnum[OUT_W-1:0] ^ randnum[RAND_W-1 -: OUT_W];
endmodule

// File: rtl/rand_range_sampler.sv
// rand_range_sampler: rejection-samples [0,BOUND) from a generator word with capped retries and a halved fallback; ports clk, rst, bus (slave)
module rand_range_sampler
  import rand_range_sampler_pkg::*;
#(
  parameter int RAND_W = RAND_W_DEF,
  parameter int OUT_W = 10,
  parameter int BOUND = 640,
  parameter int MAX_TRIES = 8,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  rand_range_sampler_if.slave bus
);
  localparam int TW = $clog2(MAX_TRIES) + 1;
  state_t state;
  logic [TW-1:0] tries;
  logic [OUT_W-1:0] cand;
  logic in_range, last;
  logic [CNT_W-1:0] cnt_next;
  rand_range_sampler_fold #(.RAND_W(RAND_W), .OUT_W(OUT_W)) u_fold (.randnum(bus.randnum), .cand(cand));
  assign in_range = {1'b0, cand} < (OUT_W+1)'(BOUND);
  assign last = tries == TW'(MAX_TRIES - 1);
  assign cnt_next = &bus.reject_cnt ? bus.reject_cnt : bus.reject_cnt + 1'b1;
  assign bus.req_ready = (state == IDLE) | ((state == HOLD) & bus.out_ready);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tries <= '0;
      bus.out_valid <= 1'b0;
      bus.rand_out <= '0;
      bus.fallback <= 1'b0;
      bus.reject_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req) begin
          state <= DRAW;
          tries <= '0;
        end
        DRAW: if (in_range) begin
          bus.rand_out <= cand;
          bus.fallback <= 1'b0;
          bus.out_valid <= 1'b1;
          state <= HOLD;
        end else begin
          bus.reject_cnt <= cnt_next;
          if (last) begin
            bus.rand_out <= cand >> 1;
            bus.fallback <= 1'b1;
            bus.out_valid <= 1'b1;
            state <= HOLD;
          end else begin
            tries <= tries + 1'b1;
          end
        end
        HOLD: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          tries <= '0;
          state <= bus.req ? DRAW : IDLE;
        end
        default: begin
          state <= IDLE;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
